// File: rtl/decode_pipe_if.sv
// Handshake bundle between instruction fetch, decode_pipe and the ALU/register-file stage.
// The decoder uses the slave view; the fetch/consumer side uses the master view.
interface decode_pipe_if #(
    parameter int OP_W = 4
);
    logic            en;
    logic            flush;
    logic            in_valid;
    logic [OP_W-1:0] in_opcode;
    logic            in_ready;
    logic            out_valid;
    logic            out_ready;
    logic [2:0]      out_alu_ctrl;
    logic [1:0]      out_update_flags;
    logic [1:0]      out_regfile_ctrl;
    logic            out_branch;
    logic            out_illegal;
    logic [OP_W-1:0] out_opcode;
    logic            busy;

    modport slave (
        input  en, flush, in_valid, in_opcode, out_ready,
        output in_ready, out_valid, out_alu_ctrl, out_update_flags, out_regfile_ctrl,
               out_branch, out_illegal, out_opcode, busy
    );

    modport master (
        output en, flush, in_valid, in_opcode, out_ready,
        input  in_ready, out_valid, out_alu_ctrl, out_update_flags, out_regfile_ctrl,
               out_branch, out_illegal, out_opcode, busy
    );
endinterface

// File: rtl/decode_pipe.sv
// Registered micro-op decoder with valid/ready flow control, branch/illegal flags and flush.
// Define DECODE_MUL_EN to enable the multi-cycle MUL sub-op and its STALL state.
module decode_pipe #(
    parameter int OP_W    = 4,
    parameter int MUL_LAT = 3
) (
    input  logic         clk,
    input  logic         rst,
    decode_pipe_if.slave bus
);
    if (OP_W < 4) begin : g_bad_op_w
        $error("decode_pipe: OP_W must be at least 4");
    end
    if (MUL_LAT < 1 || MUL_LAT > 15) begin : g_bad_mul_lat
        $error("decode_pipe: MUL_LAT must be in 1..15");
    end

    typedef enum logic [2:0] {
        SUB_ADD = 3'd0,
        SUB_SUB = 3'd1,
        SUB_AND = 3'd2,
        SUB_OR  = 3'd3,
        SUB_LDA = 3'd4,
        SUB_LDB = 3'd5,
        SUB_MUL = 3'd6,
        SUB_NOP = 3'd7
    } subop_e;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_MUL = 3'b100;

    subop_e     sub_op;
    logic       rsvd;
    logic [2:0] dec_alu;
    logic [1:0] dec_flags;
    logic [1:0] dec_rf;
    logic       dec_branch;
    logic       dec_illegal;

    assign sub_op = subop_e'(bus.in_opcode[2:0]);

    if (OP_W > 4) begin : g_rsvd
        assign rsvd = |bus.in_opcode[OP_W-2:3];
    end else begin : g_no_rsvd
        assign rsvd = 1'b0;
    end

    always_comb begin
        // NOTE: every output is given a default before any branch so no path can infer a latch.
        dec_alu     = ALU_ADD;
        dec_flags   = 2'b00;
        dec_rf      = 2'b00;
        dec_branch  = 1'b0;
        dec_illegal = 1'b0;
        if (bus.en) begin
            if (bus.in_opcode[OP_W-1]) begin
                dec_branch = 1'b1;
            end else if (rsvd) begin
                dec_illegal = 1'b1;
            end else begin
                case (sub_op)
                    SUB_ADD, SUB_SUB: begin
                        dec_alu   = bus.in_opcode[2:0];
                        dec_flags = 2'b11;
                        dec_rf    = 2'b01;
                    end
                    SUB_AND, SUB_OR: begin
                        dec_alu   = bus.in_opcode[2:0];
                        dec_flags = 2'b10;
                        dec_rf    = 2'b01;
                    end
                    SUB_LDA: dec_rf = 2'b11;
                    SUB_LDB: dec_rf = 2'b10;
`ifdef DECODE_MUL_EN
                    SUB_MUL: begin
                        dec_alu   = ALU_MUL;
                        dec_flags = 2'b10;
                        dec_rf    = 2'b01;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    logic            out_valid_q;
    logic [2:0]      alu_q;
    logic [1:0]      flags_q;
    logic [1:0]      rf_q;
    logic            branch_q;
    logic            illegal_q;
    logic [OP_W-1:0] opcode_q;
    logic            in_ready;
    logic            accept;
    logic            consume;

    assign accept  = bus.in_valid && in_ready;
    assign consume = out_valid_q && bus.out_ready;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            out_valid_q <= 1'b0;
            alu_q       <= '0;
            flags_q     <= '0;
            rf_q        <= '0;
            branch_q    <= 1'b0;
            illegal_q   <= 1'b0;
            opcode_q    <= '0;
        end else if (bus.flush) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            alu_q       <= dec_alu;
            flags_q     <= dec_flags;
            rf_q        <= dec_rf;
            branch_q    <= dec_branch;
            illegal_q   <= dec_illegal;
            opcode_q    <= bus.in_opcode;
        end else if (consume) begin
            out_valid_q <= 1'b0;
        end
    end

`ifdef DECODE_MUL_EN
    typedef enum logic {ST_RUN, ST_STALL} state_e;

    localparam logic [3:0] STALL_LEN = 4'(MUL_LAT - 1);

    state_e     state;
    state_e     state_nx;
    logic [3:0] cnt;
    logic [3:0] cnt_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // A consumed MUL word holds off issue for MUL_LAT-1 further cycles.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (bus.flush) begin
            state_nx = ST_RUN;
            cnt_nx   = '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (consume && alu_q == ALU_MUL && MUL_LAT > 1) begin
                        state_nx = ST_STALL;
                        cnt_nx   = STALL_LEN;
                    end
                end
                ST_STALL: begin
                    cnt_nx = cnt - 4'd1;
                    if (cnt <= 4'd1) state_nx = ST_RUN;
                end
                default: begin
                    state_nx = ST_RUN;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    // A held MUL word is never replaced in the cycle it leaves.
    assign in_ready = (state == ST_RUN) && !bus.flush &&
                      (!out_valid_q || (bus.out_ready && alu_q != ALU_MUL));
    assign bus.busy = (state == ST_STALL);
`else
    assign in_ready = !bus.flush && (!out_valid_q || bus.out_ready);
    assign bus.busy = 1'b0;
`endif

    assign bus.in_ready         = in_ready;
    assign bus.out_valid        = out_valid_q;
    assign bus.out_alu_ctrl     = alu_q;
    assign bus.out_update_flags = flags_q;
    assign bus.out_regfile_ctrl = rf_q;
    assign bus.out_branch       = branch_q;
    assign bus.out_illegal      = illegal_q;
    assign bus.out_opcode       = opcode_q;
endmodule

// File: doc/decode_pipe.md
# decode_pipe

Registered, handshaked successor to the combinational micro-op decoder in `rtl/micro`. It is parametrised in opcode width and adds an output pipeline register with valid/ready flow control, illegal-opcode detection, branch flush, and a multi-cycle MUL operation that stalls issue for a configurable latency. It sits between instruction fetch and the ALU/register-file stage.

## Interface
Parameters:
- `OP_W`, default 4: opcode width, ≥4. `opcode[OP_W-1]` is the branch bit, `opcode[2:0]` is the sub-op, and `opcode[OP_W-2:3]` are reserved.
- `MUL_LAT`, default 3: MUL occupancy in cycles, range 1..15.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous and active-high.
- `en` in 1: global decode enable. When low, accepted instructions decode as NOP.
- `flush` in 1: synchronous pipeline flush.
- `in_valid` in 1: instruction offered.
- `in_opcode` in OP_W: instruction opcode.
- `in_ready` out 1: the block accepts an instruction this cycle.
- `out_valid` out 1: decoded word present.
- `out_ready` in 1: downstream consumes the decoded word.
- `out_alu_ctrl` out 3: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 MUL.
- `out_update_flags` out 2: [0] C/V, [1] N/Z.
- `out_regfile_ctrl` out 2: 00 none, 01 write ALU result, 10 LDB, 11 LDA.
- `out_branch` out 1: branch opcode.
- `out_illegal` out 1: nonzero reserved bits.
- `out_opcode` out OP_W: registered copy of the accepted opcode.
- `busy` out 1: the FSM is in STALL.

## Operation
- Sub-op encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 LDA, 5 LDB, 6 MUL, 7 NOP.
- Decode on acceptance, with the first matching rule taking priority:
  - `en`=0: all control fields are 0, `out_branch`=0, `out_illegal`=0.
  - Branch bit set: all control fields are 0 and `out_branch`=1. Reserved bits are ignored.
  - Reserved bits nonzero: all control fields are 0 and `out_illegal`=1.
  - ADD/SUB: alu = op, flags = 11, regfile = 01.
  - AND/OR: alu = op, flags = 10, regfile = 01.
  - MUL: alu = 100, flags = 10, regfile = 01.
  - LDA: alu = 000, flags = 00, regfile = 11.
  - LDB: alu = 000, flags = 00, regfile = 10.
  - NOP: all fields 0.
- FSM states:
  - RUN: normal issue.
  - STALL: MUL occupancy. `in_ready`=0 and `out_valid`=0.
- `in_ready` = RUN && !`flush` && (!`out_valid` || (`out_ready` && `out_alu_ctrl`≠100)). A held MUL word therefore never overlaps a new acceptance.
- Acceptance (`in_valid` && `in_ready`) loads the output register. `out_valid`=1 on the next cycle.
- A consume without an acceptance clears `out_valid` on the next cycle.
- RUN→STALL: when a MUL word is consumed and MUL_LAT>1. The counter loads MUL_LAT-1.
- STALL: the counter decrements each cycle. STALL→RUN when the counter reaches 1 and decrements, so STALL lasts exactly MUL_LAT-1 cycles.
- If MUL_LAT=1, a consumed MUL returns the block to normal RUN issue on the next cycle with no STALL.
- `flush`=1:
  - Next cycle: `out_valid`=0, state = RUN, counter = 0.
  - No acceptance occurs in the flush cycle.
  - `flush` has priority over consume, acceptance and STALL.
- `rst` has priority over everything, including `flush`.
- Output fields hold their value while `out_valid`=1 && `out_ready`=0.

## Timing
- Reset values: `out_valid`=0, every control output 0, `out_opcode`=0, `busy`=0, state = RUN, counter = 0. `in_ready`=1 in the first cycle after reset, provided `flush`=0.
- Latency: 1 cycle from acceptance to `out_valid`.
- Throughput: 1 instruction per cycle for non-MUL opcodes with `out_ready` held high.
- MUL issue gap: a MUL occupies the slot for 1+(MUL_LAT-1) cycles after it is consumed before the next acceptance. Example, MUL_LAT=3: MUL consumed in cycle t; `busy` in t+1 and t+2; `in_ready`=1 in t+3.
- Reset mid-STALL: RUN on the next cycle, with `in_ready`=1.
- `en` is sampled only in the acceptance cycle.

## Configuration
- `DECODE_MUL_EN` defined: MUL decodes as above, and the STALL state and counter are present.
- Not defined:
  - Sub-op 6 decodes exactly as NOP (all fields 0, `out_illegal`=0).
  - No STALL state; `busy` is tied to 0.
  - `in_ready` = !`flush` && (!`out_valid` || `out_ready`).
  - MUL_LAT is ignored.

## Test plan
- Reset, then ADD (0x0) with `out_ready`=1: next cycle `out_valid`=1, alu 000, flags 11, regfile 01. Follow with back-to-back AND/LDA/LDB: 1 word per cycle, flags 10 / regfile 11 / regfile 10.
- Branch 0x8 and NOP 0x7: all fields 0, `out_branch`=1 for 0x8 only. `en`=0 with SUB: all fields 0.
- OP_W=6, opcode 0b001001: `out_illegal`=1 with fields 0. Opcode 0b100001: `out_branch`=1, `out_illegal`=0.
- `DECODE_MUL_EN`, MUL_LAT=3: MUL then SUB, `out_ready`=1. MUL out at t, `busy` at t+1..t+2, SUB accepted at t+3. Without the macro: opcode 6 gives all fields 0 and no gap.
- Backpressure: `out_ready`=0 for 4 cycles with OR held. Fields stable, `in_ready`=0. Release: consumed, next accepted the same cycle.
- Flush during STALL and with `out_valid`=1: next cycle `out_valid`=0, `busy`=0, `in_ready`=1. `rst` asserted with `flush` gives reset values.
